nfc_cmd_arbiter: RTL and testbench
==================================

// Module: nfc_cmd_arbiter
// PURPOSE
// - Shares the single MFRC522 register-command port (mfrc522_interface) between nfc_card_detector (DET) and auth_controller (AUTH).
// - Registered arbiter: captures one command, issues it downstream, routes rdata/done to its owner.
// - Lock: an owner holds the port across multi-command bursts. Timeout watchdog on done. Starvation guard.
// PARAMETERS
// - DONE_TIMEOUT_CYCLES  32'd4096  max cycles waiting nfc_cmd_done after downstream accept
// - LOCK_IDLE_CYCLES     32'd2048  max cycles a locked owner may sit without issuing before forced release
// - MAX_CONSEC_AUTH      4'd8      consecutive AUTH grants allowed while DET is waiting
// PORTS
// - clk               in   1  system clock
// - rst_n             in   1  asynchronous active-low reset
// - det_cmd_valid     in   1  DET command request
// - det_cmd_ready     out  1  DET command accepted (1-cycle pulse, combinational in accept cycle)
// - det_cmd_write     in   1  1=register write, 0=read
// - det_cmd_addr      in   6  MFRC522 register address
// - det_cmd_wdata     in   8  write data
// - det_cmd_lock      in   1  keep ownership after this command completes
// - det_cmd_rdata     out  8  read data, valid with det_cmd_done
// - det_cmd_done      out  1  completion pulse
// - det_cmd_error     out  1  with det_cmd_done: command timed out
// - auth_cmd_*        same set and widths as det_cmd_*, for AUTH
// - nfc_cmd_valid     out  1  to mfrc522_interface
// - nfc_cmd_ready     in   1
// - nfc_cmd_write     out  1
// - nfc_cmd_addr      out  6
// - nfc_cmd_wdata     out  8
// - nfc_cmd_rdata     in   8
// - nfc_cmd_done      in   1
// - owner             out  2  00 none, 01 DET, 10 AUTH (registered)
// - timeout_pulse     out  1  1-cycle pulse on any done-timeout or lock-idle release
// BEHAVIOUR
// - Reset: all outputs 0, owner=00, state IDLE, counters 0. Reset mid-transaction abandons it; no done delivered.
// - States: IDLE, ISSUE, WAIT_DONE, HOLD.
// - IDLE: one requester valid -> grant it. Both valid -> AUTH, unless consec_auth>=MAX_CONSEC_AUTH -> DET.
//   Grant cycle: pulse winner's *_cmd_ready, latch write/addr/wdata/lock, set owner -> ISSUE.
//   consec_auth: +1 (saturating) per AUTH grant while DET valid; cleared on any DET grant.
// - ISSUE: nfc_cmd_valid=1 with latched fields, held stable until nfc_cmd_ready sampled 1 -> WAIT_DONE, wd counter=0.
//   No timeout in ISSUE.
// - WAIT_DONE: counter increments each cycle.
//   nfc_cmd_done -> next cycle owner *_cmd_done=1, *_cmd_rdata=registered nfc_cmd_rdata, error=0.
//   Counter reaches DONE_TIMEOUT_CYCLES first -> owner done=1, error=1, rdata=8'h00, timeout_pulse=1.
//   Completion: latched lock=1 -> HOLD (owner kept); else -> IDLE, owner=00.
//   done and timeout in same cycle: done wins, error=0.
// - HOLD: only owner can be granted (same grant rules as IDLE); other requester stalls, ready=0.
//   Owner lock low with valid low -> IDLE, owner=00.
//   Owner valid -> accept, ISSUE (lock re-latched).
//   Idle counter reaches LOCK_IDLE_CYCLES -> timeout_pulse, IDLE, owner=00.
// - nfc_cmd_done outside WAIT_DONE (late after timeout) is ignored; never routed.
// - Non-owner *_cmd_done/error/rdata held 0. At most one *_cmd_ready per cycle. Latency valid->ready >=1 cycle.
// - Counters are 32-bit, saturate, never wrap.
// STRUCTURE
// - Package nfc_arb_pkg:
//   - arb_state_t enum (IDLE, ISSUE, WAIT_DONE, HOLD)
//   - owner_t encoding (OWN_NONE=2'b00, OWN_DET=2'b01, OWN_AUTH=2'b10)
//   - nfc_cmd_t struct {write, addr[5:0], wdata[7:0]}
// - No sub-module: single FSM, one shared wd/idle counter (cleared on state entry), consec_auth counter.
// - main_core replaces its combinational det/auth mux with this block.
// TESTING
// - DET alone: read addr 6'h04 -> nfc_cmd_valid addr=04 write=0. Model returns 8'h2A.
//   Expect det_cmd_done with rdata=8'h2A, error=0, owner back to 00.
// - DET and AUTH valid same cycle: AUTH granted first. DET granted after AUTH completes (AUTH lock=0).
// - AUTH valid every cycle, DET waiting: DET granted on the 9th arbitration (after 8 AUTH grants); consec_auth then 0.
// - AUTH lock=1 burst of 3 writes: DET request stalls (ready=0) for the whole burst.
//   DET granted only after AUTH drops lock; owner stays 10 throughout the burst.
// - Model withholds done: auth_cmd_done with error=1, rdata=00 exactly DONE_TIMEOUT_CYCLES after accept, timeout_pulse=1.
//   A later stray nfc_cmd_done is ignored.
// - rst_n low during WAIT_DONE: all outputs 0 immediately. After release a fresh DET read completes normally.

Source files
------------

// File: rtl/nfc_arb_pkg.sv
// Shared types for the MFRC522 command-port arbiter: FSM states, owner encoding
// and the latched command record.
package nfc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    HOLD      = 2'd3
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_DET  = 2'b01,
    OWN_AUTH = 2'b10
  } owner_t;

  typedef struct packed {
    logic       write;
    logic [5:0] addr;
    logic [7:0] wdata;
  } nfc_cmd_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/nfc_cmd_arbiter.sv
// Registered arbiter sharing the MFRC522 register-command port between the card
// detector (DET) and the auth controller (AUTH), with ownership lock, done watchdog
// and starvation guard.
module nfc_cmd_arbiter
  import nfc_arb_pkg::*;
#(
  parameter logic [31:0] DONE_TIMEOUT_CYCLES = 32'd4096,
  parameter logic [31:0] LOCK_IDLE_CYCLES    = 32'd2048,
  parameter logic [3:0]  MAX_CONSEC_AUTH     = 4'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       det_cmd_valid,
  output logic       det_cmd_ready,
  input  logic       det_cmd_write,
  input  logic [5:0] det_cmd_addr,
  input  logic [7:0] det_cmd_wdata,
  input  logic       det_cmd_lock,
  output logic [7:0] det_cmd_rdata,
  output logic       det_cmd_done,
  output logic       det_cmd_error,
  input  logic       auth_cmd_valid,
  output logic       auth_cmd_ready,
  input  logic       auth_cmd_write,
  input  logic [5:0] auth_cmd_addr,
  input  logic [7:0] auth_cmd_wdata,
  input  logic       auth_cmd_lock,
  output logic [7:0] auth_cmd_rdata,
  output logic       auth_cmd_done,
  output logic       auth_cmd_error,
  output logic       nfc_cmd_valid,
  input  logic       nfc_cmd_ready,
  output logic       nfc_cmd_write,
  output logic [5:0] nfc_cmd_addr,
  output logic [7:0] nfc_cmd_wdata,
  input  logic [7:0] nfc_cmd_rdata,
  input  logic       nfc_cmd_done,
  output logic [1:0] owner,
  output logic       timeout_pulse
);

  arb_state_t  state_q;
  owner_t      owner_q;
  nfc_cmd_t    cmd_q;
  logic        lock_q;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic [3:0]  consec_q;
  logic [1:0]  req_q;
  logic        det_done_q, det_err_q, auth_done_q, auth_err_q, tmo_q;
  logic [7:0]  det_rdata_q, auth_rdata_q;

  logic grant_det, grant_auth;
  logic det_elig, auth_elig;
  logic issuing, wd_expire, idle_expire;
  logic own_valid, own_lock;

  // A request must have been seen on the previous edge before it can be granted,
  // which keeps valid->ready latency at one cycle or more.
  assign det_elig    = det_cmd_valid  & req_q[0];
  assign auth_elig   = auth_cmd_valid & req_q[1];
  assign cnt_d       = sat_inc32(cnt_q);
  assign wd_expire   = (cnt_d >= DONE_TIMEOUT_CYCLES);
  assign idle_expire = (cnt_d >= LOCK_IDLE_CYCLES);
  assign own_valid   = (owner_q == OWN_DET) ? det_cmd_valid : auth_cmd_valid;
  assign own_lock    = (owner_q == OWN_DET) ? det_cmd_lock  : auth_cmd_lock;

  always_comb begin
    grant_det  = 1'b0;
    grant_auth = 1'b0;
    case (state_q)
      IDLE: begin
        if (det_elig && auth_elig) begin
          if (consec_q >= MAX_CONSEC_AUTH) grant_det = 1'b1;
          else                             grant_auth = 1'b1;
        end else begin
          grant_det  = det_elig;
          grant_auth = auth_elig;
        end
      end
      HOLD: begin
        grant_det  = (owner_q == OWN_DET)  && det_elig;
        grant_auth = (owner_q == OWN_AUTH) && auth_elig;
      end
      default: ;
    endcase
  end

  assign det_cmd_ready  = grant_det;
  assign auth_cmd_ready = grant_auth;

  assign issuing        = (state_q == ISSUE);
  assign nfc_cmd_valid  = issuing;
  assign nfc_cmd_write  = issuing & cmd_q.write;
  assign nfc_cmd_addr   = issuing ? cmd_q.addr  : 6'd0;
  assign nfc_cmd_wdata  = issuing ? cmd_q.wdata : 8'd0;

  assign owner          = owner_q;
  assign timeout_pulse  = tmo_q;
  assign det_cmd_done   = det_done_q;
  assign det_cmd_error  = det_err_q;
  assign det_cmd_rdata  = det_rdata_q;
  assign auth_cmd_done  = auth_done_q;
  assign auth_cmd_error = auth_err_q;
  assign auth_cmd_rdata = auth_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      cmd_q        <= '0;
      lock_q       <= 1'b0;
      cnt_q        <= 32'd0;
      consec_q     <= 4'd0;
      req_q        <= 2'b00;
      det_done_q   <= 1'b0;
      det_err_q    <= 1'b0;
      det_rdata_q  <= 8'd0;
      auth_done_q  <= 1'b0;
      auth_err_q   <= 1'b0;
      auth_rdata_q <= 8'd0;
      tmo_q        <= 1'b0;
    end else begin
      det_done_q   <= 1'b0;
      det_err_q    <= 1'b0;
      det_rdata_q  <= 8'd0;
      auth_done_q  <= 1'b0;
      auth_err_q   <= 1'b0;
      auth_rdata_q <= 8'd0;
      tmo_q        <= 1'b0;
      req_q        <= {auth_cmd_valid, det_cmd_valid};

      if (grant_det || grant_auth) begin
        cmd_q   <= grant_det ? nfc_cmd_t'{det_cmd_write, det_cmd_addr, det_cmd_wdata}
                             : nfc_cmd_t'{auth_cmd_write, auth_cmd_addr, auth_cmd_wdata};
        lock_q  <= grant_det ? det_cmd_lock : auth_cmd_lock;
        owner_q <= grant_det ? OWN_DET : OWN_AUTH;
        state_q <= ISSUE;
        cnt_q   <= 32'd0;
        // Starvation guard: count AUTH wins that happen while DET is asking.
        if (grant_det)                                  consec_q <= 4'd0;
        else if (det_cmd_valid && (consec_q != 4'hF))   consec_q <= consec_q + 4'd1;
      end else begin
        case (state_q)
          ISSUE: begin
            if (nfc_cmd_ready) begin
              state_q <= WAIT_DONE;
              cnt_q   <= 32'd0;
            end
          end
          WAIT_DONE: begin
            if (nfc_cmd_done || wd_expire) begin
              // A real done in the expiry cycle still counts as a clean completion.
              if (owner_q == OWN_DET) begin
                det_done_q  <= 1'b1;
                det_err_q   <= ~nfc_cmd_done;
                det_rdata_q <= nfc_cmd_done ? nfc_cmd_rdata : 8'd0;
              end else begin
                auth_done_q  <= 1'b1;
                auth_err_q   <= ~nfc_cmd_done;
                auth_rdata_q <= nfc_cmd_done ? nfc_cmd_rdata : 8'd0;
              end
              tmo_q <= ~nfc_cmd_done;
              cnt_q <= 32'd0;
              if (lock_q) begin
                state_q <= HOLD;
              end else begin
                state_q <= IDLE;
                owner_q <= OWN_NONE;
              end
            end else begin
              cnt_q <= cnt_d;
            end
          end
          HOLD: begin
            if (!own_lock && !own_valid) begin
              state_q <= IDLE;
              owner_q <= OWN_NONE;
              cnt_q   <= 32'd0;
            end else if (idle_expire) begin
              tmo_q   <= 1'b1;
              state_q <= IDLE;
              owner_q <= OWN_NONE;
              cnt_q   <= 32'd0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          default: cnt_q <= 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nfc_cmd_arbiter.sv
// Directed bench for nfc_cmd_arbiter: a downstream MFRC522 model plus a completion
// scoreboard checked with immediate assertions.
module tb_nfc_cmd_arbiter;
  import nfc_arb_pkg::*;

  localparam logic [31:0] T_DONE = 32'd40;
  localparam logic [31:0] T_IDLE = 32'd30;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       det_cmd_valid, det_cmd_ready, det_cmd_write, det_cmd_lock;
  logic [5:0] det_cmd_addr;
  logic [7:0] det_cmd_wdata, det_cmd_rdata;
  logic       det_cmd_done, det_cmd_error;
  logic       auth_cmd_valid, auth_cmd_ready, auth_cmd_write, auth_cmd_lock;
  logic [5:0] auth_cmd_addr;
  logic [7:0] auth_cmd_wdata, auth_cmd_rdata;
  logic       auth_cmd_done, auth_cmd_error;
  logic       nfc_cmd_valid, nfc_cmd_ready, nfc_cmd_write;
  logic [5:0] nfc_cmd_addr;
  logic [7:0] nfc_cmd_wdata, nfc_cmd_rdata;
  logic       nfc_cmd_done;
  logic [1:0] owner;
  logic       timeout_pulse;

  always #5 clk = ~clk;

  nfc_cmd_arbiter #(
    .DONE_TIMEOUT_CYCLES(T_DONE),
    .LOCK_IDLE_CYCLES   (T_IDLE),
    .MAX_CONSEC_AUTH    (4'd8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .det_cmd_valid(det_cmd_valid), .det_cmd_ready(det_cmd_ready),
    .det_cmd_write(det_cmd_write), .det_cmd_addr(det_cmd_addr),
    .det_cmd_wdata(det_cmd_wdata), .det_cmd_lock(det_cmd_lock),
    .det_cmd_rdata(det_cmd_rdata), .det_cmd_done(det_cmd_done),
    .det_cmd_error(det_cmd_error),
    .auth_cmd_valid(auth_cmd_valid), .auth_cmd_ready(auth_cmd_ready),
    .auth_cmd_write(auth_cmd_write), .auth_cmd_addr(auth_cmd_addr),
    .auth_cmd_wdata(auth_cmd_wdata), .auth_cmd_lock(auth_cmd_lock),
    .auth_cmd_rdata(auth_cmd_rdata), .auth_cmd_done(auth_cmd_done),
    .auth_cmd_error(auth_cmd_error),
    .nfc_cmd_valid(nfc_cmd_valid), .nfc_cmd_ready(nfc_cmd_ready),
    .nfc_cmd_write(nfc_cmd_write), .nfc_cmd_addr(nfc_cmd_addr),
    .nfc_cmd_wdata(nfc_cmd_wdata), .nfc_cmd_rdata(nfc_cmd_rdata),
    .nfc_cmd_done(nfc_cmd_done),
    .owner(owner), .timeout_pulse(timeout_pulse)
  );

  typedef struct {
    logic [1:0] who;
    logic [7:0] rd;
    logic       err;
  } exp_t;

  exp_t     sb[$];
  nfc_cmd_t nfc_exp[$];
  int       vectors = 0;
  int       miscompares = 0;
  int       cyc = 0;
  int       acc_cyc = 0;
  int       last_done_cyc = 0;
  bit       withhold = 0;
  bit       stray = 0;
  bit       burst_on = 0;
  bit       burst_done = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mdl_rd(input logic [5:0] a);
    return (a == 6'h04) ? 8'h2A : {2'b11, a};
  endfunction

  task automatic push(input logic [1:0] who, input logic w, input logic [5:0] a,
                      input logic [7:0] d, input logic err);
    nfc_cmd_t c;
    c.write = w; c.addr = a; c.wdata = d;
    nfc_exp.push_back(c);
    sb.push_back('{who, (w || err) ? 8'h00 : mdl_rd(a), err});
  endtask

  task automatic req(input logic [1:0] who, input logic w, input logic [5:0] a,
                     input logic [7:0] d, input logic lk);
    int   n;
    logic rdy;
    @(posedge clk); #1;
    if (who == OWN_DET) begin
      det_cmd_valid = 1; det_cmd_write = w; det_cmd_addr = a; det_cmd_wdata = d; det_cmd_lock = lk;
    end else begin
      auth_cmd_valid = 1; auth_cmd_write = w; auth_cmd_addr = a; auth_cmd_wdata = d; auth_cmd_lock = lk;
    end
    n = 0; rdy = 0;
    while (!rdy && n < 3000) begin
      @(negedge clk);
      n++;
      rdy = (who == OWN_DET) ? det_cmd_ready : auth_cmd_ready;
    end
    check((who == OWN_DET) ? "det_grant" : "auth_grant", 32'(rdy), 32'd1);
    @(posedge clk); #1;
    if (who == OWN_DET) det_cmd_valid = 0;
    else                auth_cmd_valid = 0;
  endtask

  task automatic wait_sb();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("sb_drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_zero(input string pre);
    check({pre, "_req_side"}, 32'({det_cmd_ready, det_cmd_done, det_cmd_error, det_cmd_rdata,
                                   auth_cmd_ready, auth_cmd_done, auth_cmd_error, auth_cmd_rdata}), 32'd0);
    check({pre, "_nfc_side"}, 32'({nfc_cmd_valid, nfc_cmd_write, nfc_cmd_addr, nfc_cmd_wdata,
                                   owner, timeout_pulse}), 32'd0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream MFRC522 model: ready one cycle after valid, done 3 cycles after accept.
  initial begin
    logic     acc, seen;
    int       pend;
    logic [7:0] pend_rd;
    nfc_cmd_t got, e;
    nfc_cmd_ready = 0; nfc_cmd_done = 0; nfc_cmd_rdata = 0;
    pend = 0; pend_rd = 0;
    forever begin
      @(negedge clk);
      acc  = nfc_cmd_valid && nfc_cmd_ready;
      seen = nfc_cmd_valid && !nfc_cmd_ready;
      if (acc) begin
        acc_cyc = cyc + 1;
        got.write = nfc_cmd_write; got.addr = nfc_cmd_addr; got.wdata = nfc_cmd_wdata;
        if (nfc_exp.size() == 0) check("nfc_unexpected_cmd", 32'(got), 32'h7FFF_FFFF);
        else begin
          e = nfc_exp.pop_front();
          check("nfc_cmd", 32'(got), 32'(e));
        end
        pend_rd = nfc_cmd_write ? 8'h00 : mdl_rd(nfc_cmd_addr);
      end
      @(posedge clk); #1;
      nfc_cmd_done = 0; nfc_cmd_rdata = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin nfc_cmd_done = 1; nfc_cmd_rdata = pend_rd; end
      end
      if (acc) begin
        nfc_cmd_ready = 0;
        pend = withhold ? 0 : 3;
      end else if (seen) nfc_cmd_ready = 1;
      if (stray) begin nfc_cmd_done = 1; nfc_cmd_rdata = 8'hEE; stray = 0; end
    end
  end

  // Completion monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (det_cmd_ready || auth_cmd_ready)
        check("one_ready", 32'(det_cmd_ready & auth_cmd_ready), 32'd0);
      if (det_cmd_done || auth_cmd_done) begin
        last_done_cyc = cyc;
        if (sb.size() == 0) check("unexpected_done", 32'({auth_cmd_done, det_cmd_done}), 32'd0);
        else begin
          e = sb.pop_front();
          check("done_who", 32'({auth_cmd_done, det_cmd_done}), 32'(e.who));
          if (e.who == OWN_DET) begin
            check("det_rdata", 32'(det_cmd_rdata), 32'(e.rd));
            check("det_error", 32'(det_cmd_error), 32'(e.err));
            check("auth_quiet", 32'({auth_cmd_error, auth_cmd_rdata}), 32'd0);
          end else begin
            check("auth_rdata", 32'(auth_cmd_rdata), 32'(e.rd));
            check("auth_error", 32'(auth_cmd_error), 32'(e.err));
            check("det_quiet", 32'({det_cmd_error, det_cmd_rdata}), 32'd0);
          end
          check("done_tmo_pulse", 32'(timeout_pulse), 32'(e.err));
          if (e.err) check("tmo_latency", 32'(cyc - acc_cyc), T_DONE);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL global_watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 0;
    det_cmd_valid = 0; det_cmd_write = 0; det_cmd_addr = 0; det_cmd_wdata = 0; det_cmd_lock = 0;
    auth_cmd_valid = 0; auth_cmd_write = 0; auth_cmd_addr = 0; auth_cmd_wdata = 0; auth_cmd_lock = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst_n = 1;

    // DET alone: read 0x04 -> 0x2A
    push(OWN_DET, 0, 6'h04, 8'h00, 0);
    req(OWN_DET, 0, 6'h04, 8'h00, 0);
    wait_sb();
    @(negedge clk);
    check("det_alone_owner", 32'(owner), 32'(OWN_NONE));

    // Simultaneous requests: AUTH first, then DET
    push(OWN_AUTH, 0, 6'h10, 8'h00, 0);
    push(OWN_DET,  0, 6'h05, 8'h00, 0);
    fork
      req(OWN_DET,  0, 6'h05, 8'h00, 0);
      req(OWN_AUTH, 0, 6'h10, 8'h00, 0);
    join
    wait_sb();

    // Starvation guard: DET wins the 9th arbitration
    for (int i = 0; i < 8; i++) push(OWN_AUTH, 0, 6'(6'h20 + i), 8'h00, 0);
    push(OWN_DET, 0, 6'h07, 8'h00, 0);
    push(OWN_AUTH, 0, 6'h28, 8'h00, 0);
    push(OWN_AUTH, 0, 6'h29, 8'h00, 0);
    fork
      req(OWN_DET, 0, 6'h07, 8'h00, 0);
      for (int i = 0; i < 10; i++) req(OWN_AUTH, 0, 6'(6'h20 + i), 8'h00, 0);
    join
    wait_sb();

    // AUTH locked burst of three writes; DET stalls until the lock is dropped
    push(OWN_AUTH, 1, 6'h30, 8'h11, 0);
    push(OWN_AUTH, 1, 6'h31, 8'h22, 0);
    push(OWN_AUTH, 1, 6'h32, 8'h33, 0);
    push(OWN_DET,  0, 6'h08, 8'h00, 0);
    fork
      req(OWN_DET, 0, 6'h08, 8'h00, 0);
      begin
        req(OWN_AUTH, 1, 6'h30, 8'h11, 1);
        burst_on = 1;
        req(OWN_AUTH, 1, 6'h31, 8'h22, 1);
        req(OWN_AUTH, 1, 6'h32, 8'h33, 0);
        burst_on = 0;
        burst_done = 1;
      end
      while (!burst_done) begin
        @(negedge clk);
        if (burst_on) begin
          check("burst_owner", 32'(owner), 32'(OWN_AUTH));
          check("burst_det_stall", 32'(det_cmd_ready), 32'd0);
        end
      end
    join
    wait_sb();

    // Done withheld: AUTH times out, later stray done ignored
    withhold = 1;
    push(OWN_AUTH, 0, 6'h15, 8'h00, 1);
    req(OWN_AUTH, 0, 6'h15, 8'h00, 0);
    wait_sb();
    withhold = 0;
    stray = 1;
    repeat (6) @(negedge clk);
    check("stray_owner", 32'(owner), 32'(OWN_NONE));

    // Lock held with no further commands: forced release after the idle limit
    push(OWN_AUTH, 1, 6'h16, 8'h5A, 0);
    req(OWN_AUTH, 1, 6'h16, 8'h5A, 1);
    wait_sb();
    n = 0;
    while (owner != OWN_NONE && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("lock_idle_len", 32'(cyc - last_done_cyc), T_IDLE);
    check("lock_idle_pulse", 32'(timeout_pulse), 32'd1);
    auth_cmd_lock = 0;

    // Reset while waiting for done, then a fresh read
    withhold = 1;
    nfc_exp.push_back(nfc_cmd_t'{1'b0, 6'h09, 8'h00});
    req(OWN_DET, 0, 6'h09, 8'h00, 0);
    repeat (4) @(negedge clk);
    check("pre_reset_owner", 32'(owner), 32'(OWN_DET));
    #2 rst_n = 0;
    #1 chk_zero("mid_reset");
    withhold = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    push(OWN_DET, 0, 6'h04, 8'h00, 0);
    req(OWN_DET, 0, 6'h04, 8'h00, 0);
    wait_sb();
    @(negedge clk);
    check("post_reset_owner", 32'(owner), 32'(OWN_NONE));
    check("nfc_exp_drain", 32'(nfc_exp.size()), 32'd0);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
